accel_cfg_ctrl: RTL and testbench
=================================

Name: accel_cfg_ctrl

Overview:
Parametrised multi-channel configuration and control front-end for accelerators on the internal memory-like bus, downstream of the AXI-to-memory converter.
- Splits the bus into config space (address MSB = 0) and accelerator data space (MSB = 1).
- Holds per-channel control/status registers.
- Runs one launch FSM per channel: start pulse, hardware auto-clear of the start bit, sticky done, abort, cycle counter.
- Aggregates per-channel completion into one maskable interrupt.

Parameters:
DATA_WIDTH, 32, bus/register width (multiple of 8, ≥ 32)
INT_ADDR_WIDTH, 20, byte address width of internal bus
N_CH, 2, number of accelerator channels (1..8)
CTRL_WORDS, 2, control words per channel (≥ 1)
STAT_WORDS, 2, status words per channel (≥ 2)
CNT_WIDTH, 32, run-cycle counter width (≤ DATA_WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mem_req_i  in  1  bus request
mem_addr_i  in  INT_ADDR_WIDTH  byte address
mem_we_i  in  1  write enable
mem_be_i  in  DATA_WIDTH/8  byte enables
mem_wdata_i  in  DATA_WIDTH  write data
mem_rdata_o  out  DATA_WIDTH  read data, valid 1 cycle after req
acc_mem_en_o  out  1  data-space request (req & MSB)
acc_mem_addr_o  out  INT_ADDR_WIDTH-1  data-space byte address, MSB stripped
acc_mem_we_o / acc_mem_be_o / acc_mem_wdata_o  out  1 / DATA_WIDTH/8 / DATA_WIDTH  forwarded unchanged
acc_mem_rdata_i  in  DATA_WIDTH  data-space read data, 1-cycle latency
acc_start_o  out  N_CH  one-cycle start pulse per channel
acc_abort_o  out  N_CH  one-cycle abort pulse per channel
acc_done_i  in  N_CH  one-cycle done pulse per channel
acc_err_i  in  4*N_CH  per-channel error code, sampled with done
acc_cfg_o  out  N_CH*CTRL_WORDS*DATA_WIDTH  control words, channel-major
irq_o  out  1  registered interrupt

Behaviour:
- Clocking/reset: single clock domain. rst_n is asynchronous active-low. All registers reset to 0. acc_start_o, acc_abort_o and irq_o are 0 in reset. Every FSM resets to IDLE.
- Config addressing: word index w = addr[INT_ADDR_WIDTH-2:2].
  - BLK = 2^clog2(CTRL_WORDS+STAT_WORDS).
  - Block 0 is global. Word 0 = IRQ_PEND[N_CH-1:0], write-1-to-clear. Word 1 = IRQ_EN, RW.
  - Channel c occupies block c+1: CTRL_WORDS control words, then STAT_WORDS status words.
  - Unmapped reads return 0. Unmapped writes and writes to status words are ignored.
  - Control writes honour mem_be_i per byte.
- Read path: the data/config select bit is registered; mem_rdata_o muxes config read data against acc_mem_rdata_i one cycle later. Config read data is registered (1-cycle latency). A write followed by a read of the same word returns the new value.
- Control word 0 bits: bit0 START, bit1 ABORT (write-only, reads 0). Remaining bits are user fields passed to acc_cfg_o.
- Status word 0: [1:0] state (IDLE=0, RUN=1, DONE=2), [7:4] last error, bit8 done, bit9 busy. Status word 1: run cycle count, zero-extended.
- Channel FSM:
  - IDLE/DONE → RUN when a write sets START=1. On that edge: acc_start_o[c] = 1 for exactly one cycle; done clears; counter clears to 0; busy = 1.
  - RUN: counter increments every cycle and saturates at all-ones. START reads 1. Writes to START are ignored.
  - RUN → DONE on acc_done_i[c]. START is cleared by hardware in the same cycle, err is captured, done = 1, IRQ_PEND[c] = 1.
  - RUN → IDLE on ABORT write. acc_abort_o[c] pulses for one cycle; START clears; err = 4'hF; no IRQ.
  - acc_done_i outside RUN is ignored. ABORT outside RUN is ignored.
- Simultaneous events:
  - done_i and ABORT write in the same cycle: done wins, abort is dropped.
  - Hardware START clear and a bus write to control word 0 in the same cycle: the other bits take the bus data, START clears.
  - IRQ_PEND set and W1C of the same bit in the same cycle: set wins.
- irq_o = registered OR(IRQ_PEND & IRQ_EN). It asserts 1 cycle after the pending/enable change.
- Bit and word widths are checked by static assertion. CNT_WIDTH > DATA_WIDTH is a configuration error.

Test Plan:
- Reset: assert rst_n=0 mid-RUN → all outputs 0, every status word reads 0, and the next start works normally.
- Launch ch0: write 0x1 to ch0 ctrl0 → acc_start_o[0] pulses once, status reads 0x201. Done after 10 cycles with err=3 → status 0x132, count word ≥ 10, START reads 0, IRQ_PEND = 0x1.
- Interrupt: IRQ_EN=0x1 → irq_o=1 one cycle later. W1C IRQ_PEND=0x1 → irq_o=0. W1C colliding with a fresh done → IRQ_PEND stays 1.
- Abort: ch1 running, write 0x2 → acc_abort_o[1] pulses, state IDLE, err=0xF, no IRQ. Abort and done in the same cycle → DONE, err from acc_err_i.
- Address split: read/write at 0x80000 + 0x10 (INT_ADDR_WIDTH=20) → acc_mem_en_o=1 with acc_mem_addr_o=0x10. Back-to-back cfg read then data read → each rdata returned in the correct cycle. Unmapped cfg read → 0.
- Byte enables: write 0xAABBCCDD with be=0b0100 to ch0 ctrl1 → ctrl1 reads 0x00BB0000, and acc_cfg_o shows the same value.

Source files
------------

// File: rtl/accel_cfg_ctrl.sv
// Multi-channel accelerator config/control front-end on the internal memory bus.
// Splits config/data space, holds per-channel control/status, runs launch FSMs, raises a maskable irq.
module accel_cfg_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned INT_ADDR_WIDTH = 20,
  parameter int unsigned N_CH           = 2,
  parameter int unsigned CTRL_WORDS     = 2,
  parameter int unsigned STAT_WORDS     = 2,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     mem_req_i,
  input  logic [INT_ADDR_WIDTH-1:0]                mem_addr_i,
  input  logic                                     mem_we_i,
  input  logic [DATA_WIDTH/8-1:0]                  mem_be_i,
  input  logic [DATA_WIDTH-1:0]                    mem_wdata_i,
  output logic [DATA_WIDTH-1:0]                    mem_rdata_o,
  output logic                                     acc_mem_en_o,
  output logic [INT_ADDR_WIDTH-2:0]                acc_mem_addr_o,
  output logic                                     acc_mem_we_o,
  output logic [DATA_WIDTH/8-1:0]                  acc_mem_be_o,
  output logic [DATA_WIDTH-1:0]                    acc_mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]                    acc_mem_rdata_i,
  output logic [N_CH-1:0]                          acc_start_o,
  output logic [N_CH-1:0]                          acc_abort_o,
  input  logic [N_CH-1:0]                          acc_done_i,
  input  logic [4*N_CH-1:0]                        acc_err_i,
  output logic [N_CH*CTRL_WORDS*DATA_WIDTH-1:0]    acc_cfg_o,
  output logic                                     irq_o
);
  localparam int unsigned BE_W   = DATA_WIDTH / 8;
  localparam int unsigned WORD_W = INT_ADDR_WIDTH - 3;
  localparam int unsigned BLK_W  = $clog2(CTRL_WORDS + STAT_WORDS);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

  if (DATA_WIDTH < 32 || (DATA_WIDTH % 8) != 0) begin : g_bad_dw
    $error("DATA_WIDTH must be a multiple of 8 and at least 32");
  end
  if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
    $error("N_CH must be in 1..8");
  end
  if (CTRL_WORDS < 1 || STAT_WORDS < 2) begin : g_bad_words
    $error("need CTRL_WORDS >= 1 and STAT_WORDS >= 2");
  end
  if (CNT_WIDTH > DATA_WIDTH || CNT_WIDTH < 1) begin : g_bad_cnt
    $error("CNT_WIDTH must not exceed DATA_WIDTH");
  end

  logic [DATA_WIDTH-1:0] r_ctrl [N_CH][CTRL_WORDS];
  state_e                r_state [N_CH];
  logic [3:0]            r_err [N_CH];
  logic [N_CH-1:0]       r_done;
  logic [CNT_WIDTH-1:0]  r_cnt [N_CH];
  logic [N_CH-1:0]       r_irq_pend;
  logic [N_CH-1:0]       r_irq_en;
  logic                  r_irq;
  logic [N_CH-1:0]       r_start;
  logic [N_CH-1:0]       r_abort;
  logic [DATA_WIDTH-1:0] r_cfg_rdata;
  logic                  r_sel_data;

  logic                  w_cfg_wr;
  logic                  w_cfg_rd;
  logic [WORD_W-1:0]     w_word;
  int unsigned           w_blk;
  int unsigned           w_off;
  logic [DATA_WIDTH-1:0] w_wmask;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_ctrl_wr [N_CH][CTRL_WORDS];
  logic [DATA_WIDTH-1:0] w_ctrl_next [N_CH][CTRL_WORDS];
  logic [DATA_WIDTH-1:0] w_ctrl_view [N_CH][CTRL_WORDS];
  logic [N_CH-1:0]       w_start_req;
  logic [N_CH-1:0]       w_abort_req;
  logic [N_CH-1:0]       w_pend_set;
  logic [N_CH-1:0]       w_pend_clr;
  logic                  w_en_wr;
  logic                  w_unused;

  assign w_unused = &{1'b0, mem_addr_i[1:0]};

  // Data-space pass-through with the space-select MSB stripped
  assign acc_mem_en_o    = mem_req_i & mem_addr_i[INT_ADDR_WIDTH-1];
  assign acc_mem_addr_o  = mem_addr_i[INT_ADDR_WIDTH-2:0];
  assign acc_mem_we_o    = mem_we_i;
  assign acc_mem_be_o    = mem_be_i;
  assign acc_mem_wdata_o = mem_wdata_i;

  assign w_cfg_wr = mem_req_i & ~mem_addr_i[INT_ADDR_WIDTH-1] & mem_we_i;
  assign w_cfg_rd = mem_req_i & ~mem_addr_i[INT_ADDR_WIDTH-1] & ~mem_we_i;
  assign w_word   = mem_addr_i[INT_ADDR_WIDTH-2:2];
  assign w_blk    = 32'(w_word >> BLK_W);
  assign w_off    = 32'(w_word[BLK_W-1:0]);
  assign w_en_wr  = w_cfg_wr && (w_blk == 0) && (w_off == 1);

  always_comb begin
    for (int unsigned b = 0; b < BE_W; b++) begin
      w_wmask[8*b +: 8] = {8{mem_be_i[b]}};
    end
  end

  // Control decode; START/ABORT are never stored, START reads back as the RUN state
  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      for (int unsigned k = 0; k < CTRL_WORDS; k++) begin
        w_ctrl_wr[c][k]   = w_cfg_wr && (w_blk == c + 1) && (w_off == k);
        w_ctrl_next[c][k] = (r_ctrl[c][k] & ~w_wmask) | (mem_wdata_i & w_wmask);
        w_ctrl_view[c][k] = r_ctrl[c][k];
        if (k == 0) begin
          w_ctrl_next[c][k][1:0] = 2'b00;
          w_ctrl_view[c][k][1:0] = {1'b0, r_state[c] == ST_RUN};
        end
      end
      w_start_req[c] = w_ctrl_wr[c][0] & mem_be_i[0] & mem_wdata_i[0];
      w_abort_req[c] = w_ctrl_wr[c][0] & mem_be_i[0] & mem_wdata_i[1];
      w_pend_set[c]  = (r_state[c] == ST_RUN) & acc_done_i[c];
    end
    w_pend_clr = '0;
    if (w_cfg_wr && (w_blk == 0) && (w_off == 0)) begin
      w_pend_clr = mem_wdata_i[N_CH-1:0] & w_wmask[N_CH-1:0];
    end
  end

  always_comb begin
    acc_cfg_o = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      for (int unsigned k = 0; k < CTRL_WORDS; k++) begin
        acc_cfg_o[(c*CTRL_WORDS+k)*DATA_WIDTH +: DATA_WIDTH] = w_ctrl_view[c][k];
      end
    end
  end

  // Config read mux; unmapped words read 0
  always_comb begin
    w_rdata = '0;
    if (w_blk == 0) begin
      if (w_off == 0)      w_rdata = DATA_WIDTH'(r_irq_pend);
      else if (w_off == 1) w_rdata = DATA_WIDTH'(r_irq_en);
    end
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (w_blk == c + 1) begin
        for (int unsigned k = 0; k < CTRL_WORDS; k++) begin
          if (w_off == k) w_rdata = w_ctrl_view[c][k];
        end
        if (w_off == CTRL_WORDS) begin
          w_rdata = DATA_WIDTH'({r_state[c] == ST_RUN, r_done[c], r_err[c], 2'b00, 2'(r_state[c])});
        end else if (w_off == CTRL_WORDS + 1) begin
          w_rdata = DATA_WIDTH'(r_cnt[c]);
        end
      end
    end
  end

  assign mem_rdata_o = r_sel_data ? acc_mem_rdata_i : r_cfg_rdata;
  assign acc_start_o = r_start;
  assign acc_abort_o = r_abort;
  assign irq_o       = r_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_pend  <= '0;
      r_irq_en    <= '0;
      r_irq       <= 1'b0;
      r_start     <= '0;
      r_abort     <= '0;
      r_done      <= '0;
      r_cfg_rdata <= '0;
      r_sel_data  <= 1'b0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        r_state[c] <= ST_IDLE;
        r_err[c]   <= 4'h0;
        r_cnt[c]   <= '0;
        for (int unsigned k = 0; k < CTRL_WORDS; k++) r_ctrl[c][k] <= '0;
      end
    end else begin
      r_sel_data  <= mem_req_i & mem_addr_i[INT_ADDR_WIDTH-1];
      r_cfg_rdata <= w_cfg_rd ? w_rdata : '0;
      // A hardware set beats a same-cycle write-1-to-clear
      r_irq_pend  <= (r_irq_pend & ~w_pend_clr) | w_pend_set;
      if (w_en_wr) r_irq_en <= (r_irq_en & ~w_wmask[N_CH-1:0]) | (mem_wdata_i[N_CH-1:0] & w_wmask[N_CH-1:0]);
      r_irq <= |(r_irq_pend & r_irq_en);
      for (int unsigned c = 0; c < N_CH; c++) begin
        r_start[c] <= 1'b0;
        r_abort[c] <= 1'b0;
        for (int unsigned k = 0; k < CTRL_WORDS; k++) begin
          if (w_ctrl_wr[c][k]) r_ctrl[c][k] <= w_ctrl_next[c][k];
        end
        case (r_state[c])
          ST_RUN: begin
            if (r_cnt[c] != {CNT_WIDTH{1'b1}}) r_cnt[c] <= r_cnt[c] + CNT_WIDTH'(1);
            if (acc_done_i[c]) begin
              r_state[c] <= ST_DONE;
              r_err[c]   <= acc_err_i[4*c +: 4];
              r_done[c]  <= 1'b1;
            end else if (w_abort_req[c]) begin
              r_state[c] <= ST_IDLE;
              r_err[c]   <= 4'hF;
              r_abort[c] <= 1'b1;
            end
          end
          default: begin
            if (w_start_req[c]) begin
              r_state[c] <= ST_RUN;
              r_start[c] <= 1'b1;
              r_done[c]  <= 1'b0;
              r_cnt[c]   <= '0;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_accel_cfg_ctrl.sv
// Directed self-checking bench for accel_cfg_ctrl at default parameters.
module tb_accel_cfg_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         req, we;
  logic [19:0]  addr;
  logic [3:0]   be;
  logic [31:0]  wdata, rdata;
  logic         acc_en, acc_we;
  logic [18:0]  acc_addr;
  logic [3:0]   acc_be;
  logic [31:0]  acc_wdata;
  logic [31:0]  acc_rdata;
  logic [1:0]   start, abort, done;
  logic [7:0]   err;
  logic [127:0] cfg;
  logic         irq;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start0 = 0;
  int n_start1 = 0;
  int n_abort1 = 0;

  accel_cfg_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_i(req), .mem_addr_i(addr), .mem_we_i(we), .mem_be_i(be),
    .mem_wdata_i(wdata), .mem_rdata_o(rdata),
    .acc_mem_en_o(acc_en), .acc_mem_addr_o(acc_addr), .acc_mem_we_o(acc_we),
    .acc_mem_be_o(acc_be), .acc_mem_wdata_o(acc_wdata), .acc_mem_rdata_i(acc_rdata),
    .acc_start_o(start), .acc_abort_o(abort), .acc_done_i(done), .acc_err_i(err),
    .acc_cfg_o(cfg), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Data-space memory stand-in: 1-cycle read latency, returns a tagged address
  always @(posedge clk) begin
    if (acc_en && !acc_we) acc_rdata <= 32'hDA7A_0000 | 32'(acc_addr);
  end

  always @(posedge clk) begin
    if (start[0]) n_start0++;
    if (start[1]) n_start1++;
    if (abort[1]) n_abort1++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [19:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [19:0] a, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
    @(negedge clk);
    req = 1'b0;
    d = rdata;
  endtask

  task automatic rd_check(input string tag, input logic [19:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    check(tag, 64'(d), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, a1;
    logic [31:0] d;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    done = '0; err = '0; acc_rdata = '0;
    repeat (3) @(negedge clk);
    check("reset_pulses", 64'({start, abort, irq}), 64'd0);
    check("reset_cfg", cfg[63:0], 64'd0);
    rst_n = 1'b1;

    // Launch ch0, done with err=3 after 10 cycles
    s0 = n_start0;
    bus_wr(20'h00010, 32'h1, 4'hF);
    rd_check("ch0_stat_run", 20'h00018, 32'h201);
    rd_check("ch0_start_reads1", 20'h00010, 32'h1);
    check("ch0_start_pulse", 64'(n_start0 - s0), 64'd1);
    repeat (10) @(negedge clk);
    done[0] = 1'b1; err[3:0] = 4'h3;
    @(negedge clk);
    done[0] = 1'b0;
    rd_check("ch0_stat_done", 20'h00018, 32'h132);
    bus_rd(20'h0001C, d);
    check("ch0_count_range", 64'(d >= 32'd10 && d <= 32'd20), 64'd1);
    rd_check("ch0_start_cleared", 20'h00010, 32'h0);
    rd_check("pend_after_done", 20'h00000, 32'h1);

    // Interrupt enable / W1C / collision
    bus_wr(20'h00004, 32'h1, 4'hF);
    check("irq_not_yet", 64'(irq), 64'd0);
    @(negedge clk);
    check("irq_set", 64'(irq), 64'd1);
    bus_wr(20'h00000, 32'h1, 4'hF);
    @(negedge clk);
    check("irq_cleared", 64'(irq), 64'd0);
    bus_wr(20'h00010, 32'h1, 4'hF);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 20'h00000; wdata = 32'h1; be = 4'hF;
    done[0] = 1'b1; err[3:0] = 4'h5;
    @(negedge clk);
    req = 1'b0; we = 1'b0; done[0] = 1'b0;
    rd_check("pend_set_wins", 20'h00000, 32'h1);
    rd_check("ch0_stat_err5", 20'h00018, 32'h152);
    bus_wr(20'h00000, 32'h1, 4'hF);

    // Hardware START clear colliding with a ctrl0 write
    bus_wr(20'h00010, 32'h1, 4'hF);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 20'h00010; wdata = 32'h00FF_0001; be = 4'hF;
    done[0] = 1'b1; err[3:0] = 4'h7;
    @(negedge clk);
    req = 1'b0; we = 1'b0; done[0] = 1'b0;
    rd_check("ctrl0_collide", 20'h00010, 32'h00FF_0000);
    rd_check("ch0_stat_err7", 20'h00018, 32'h172);
    check("cfg_ch0_w0", 64'(cfg[31:0]), 64'h00FF_0000);
    bus_wr(20'h00000, 32'h1, 4'hF);
    rd_check("pend_cleared", 20'h00000, 32'h0);

    // Abort ch1
    s1 = n_start1; a1 = n_abort1;
    bus_wr(20'h00020, 32'h1, 4'hF);
    bus_wr(20'h00020, 32'h2, 4'hF);
    @(negedge clk);
    check("ch1_start_pulse", 64'(n_start1 - s1), 64'd1);
    check("ch1_abort_pulse", 64'(n_abort1 - a1), 64'd1);
    rd_check("ch1_stat_abort", 20'h00028, 32'h0F0);
    rd_check("abort_no_irq", 20'h00000, 32'h0);

    // Abort and done together: done wins
    bus_wr(20'h00020, 32'h1, 4'hF);
    a1 = n_abort1;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 20'h00020; wdata = 32'h2; be = 4'hF;
    done[1] = 1'b1; err[7:4] = 4'h6;
    @(negedge clk);
    req = 1'b0; we = 1'b0; done[1] = 1'b0;
    rd_check("ch1_done_wins", 20'h00028, 32'h162);
    rd_check("pend_ch1", 20'h00000, 32'h2);
    bus_wr(20'h00000, 32'h2, 4'hF);

    // Abort, done and status writes outside RUN are ignored
    bus_wr(20'h00020, 32'h2, 4'hF);
    @(negedge clk);
    done[1] = 1'b1; err[7:4] = 4'h9;
    @(negedge clk);
    done[1] = 1'b0;
    bus_wr(20'h00028, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    check("no_abort_in_done", 64'(n_abort1 - a1), 64'd0);
    rd_check("ch1_stat_kept", 20'h00028, 32'h162);
    rd_check("pend_stays0", 20'h00000, 32'h0);

    // Byte-enabled control write
    bus_wr(20'h00014, 32'hAABB_CCDD, 4'b0100);
    rd_check("ctrl1_be", 20'h00014, 32'h00BB_0000);
    check("cfg_ch0_w1", 64'(cfg[63:32]), 64'h00BB_0000);

    // Address split and back-to-back cfg/data reads
    s0 = n_start0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 20'h80010; wdata = 32'h1; be = 4'hF;
    #1;
    check("data_en_addr", 64'({acc_en, acc_we, acc_addr}), 64'({1'b1, 1'b1, 19'h00010}));
    check("data_wdata", 64'(acc_wdata), 64'h1);
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    @(negedge clk);
    check("data_no_start", 64'(n_start0 - s0), 64'd0);
    req = 1'b1; we = 1'b0; addr = 20'h00014;
    #1;
    check("cfg_no_data_en", 64'(acc_en), 64'd0);
    @(negedge clk);
    addr = 20'h80010;
    check("b2b_cfg", 64'(rdata), 64'h00BB_0000);
    @(negedge clk);
    req = 1'b0;
    check("b2b_data", 64'(rdata), 64'hDA7A_0010);
    rd_check("unmapped_glb", 20'h00008, 32'h0);
    rd_check("unmapped_blk", 20'h00040, 32'h0);

    // Reset in the middle of a run
    bus_wr(20'h00020, 32'h1, 4'hF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_run_pulses", 64'({start, abort, irq}), 64'd0);
    check("rst_run_cfg", cfg[63:0], 64'd0);
    check("rst_run_rdata", 64'(rdata), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_check("rst_ch0_stat", 20'h00018, 32'h0);
    rd_check("rst_ch0_cnt", 20'h0001C, 32'h0);
    rd_check("rst_ch1_stat", 20'h00028, 32'h0);
    rd_check("rst_ch1_cnt", 20'h0002C, 32'h0);
    rd_check("rst_irq_en", 20'h00004, 32'h0);
    s0 = n_start0;
    bus_wr(20'h00010, 32'h1, 4'hF);
    rd_check("rst_restart_stat", 20'h00018, 32'h201);
    check("rst_restart_pulse", 64'(n_start0 - s0), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
